// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl -- instruction fetch controller with a small prefetch buffer.
//
// A three-state FSM (IDLE / RUN / HALT) walks a byte-addressed PC through an
// instruction memory that answers combinationally. Each fetched word is
// pushed, together with its PC, into a DEPTH-entry circular buffer. The head
// of the buffer is offered to the consumer with a valid/ready handshake.
// A redirect flushes the buffer and reloads the PC in a single cycle.
//
// Parameters
//   RESET_PC  PC loaded on reset (word aligned).
//   DEPTH     prefetch buffer entries; 2 or 4 (power of two, so pointers
//             wrap naturally).
//
// Ports
//   clk             clock, all state changes on the rising edge
//   rst             synchronous active-high reset
//   run             1 = fetching permitted, 0 = halt requested
//   mem_addr        byte address to instruction memory (always == pc)
//   mem_instr       instruction word at mem_addr, same cycle
//   redirect_valid  one-cycle pulse: taken jump/branch
//   redirect_pc     target byte address (low two bits ignored)
//   out_valid       buffer head holds an instruction
//   out_ready       consumer accepts the head this cycle
//   out_instr       instruction at buffer head (0 when empty)
//   out_pc          PC of out_instr (0 when empty)
//   state           FSM state: 0 = IDLE, 1 = RUN, 2 = HALT
//   fetch_count     saturating count of words pushed since reset
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic [1:0]  state,
   output logic [31:0] fetch_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t        st;
   logic [31:0]   pc;
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic          push;
   logic          pop;

   logic [31:0]   fifo_pc    [DEPTH];
   logic [31:0]   fifo_instr [DEPTH];

   // ------------------------------------------------------------------------
   // Handshake decode. A redirect suppresses both push and pop so the flush
   // cannot race with a transfer. A full buffer can still accept a push when
   // the head leaves in the same cycle, which gives one word per cycle.
   // ------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the block leaves it unassigned and no latch is inferred.
   always_comb begin
      push = 1'b0;
      pop  = 1'b0;
      if (!redirect_valid) begin
         pop  = (count != '0) && out_ready;
         push = (st == RUN) && run && ((count != CW'(DEPTH)) || pop);
      end
   end

   assign mem_addr  = pc;
   assign out_valid = (count != '0);
   assign out_instr = out_valid ? fifo_instr[head] : 32'h0;
   assign out_pc    = out_valid ? fifo_pc[head]    : 32'h0;
   assign state     = st;

   // ------------------------------------------------------------------------
   // Buffer storage. Occupancy is tracked by count, and the outputs are
   // masked while empty, so the stale contents are never observable.
   // ------------------------------------------------------------------------
   // NOTE: the storage array has no reset; clearing it would add a reset
   // path to every bit for no observable benefit.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         fifo_pc[tail]    <= pc;
         fifo_instr[tail] <= mem_instr;
      end
   end

   // ------------------------------------------------------------------------
   // Control state: FSM, PC, pointers, occupancy and the fetch counter.
   // Priority: rst, then redirect, then normal push/pop and FSM moves.
   // A redirect holds the FSM where it is.
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         st          <= IDLE;
         pc          <= RESET_PC;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         fetch_count <= 32'h0;
      end else if (redirect_valid) begin
         pc    <= redirect_pc & ~32'h3;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            pc   <= pc + 32'd4;       // modulo 2^32: FFFFFFFC wraps to 0
            tail <= tail + PW'(1);
            if (fetch_count != 32'hFFFF_FFFF)
               fetch_count <= fetch_count + 32'd1;
         end

         if (pop)
            head <= head + PW'(1);

         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);

         case (st)
            IDLE:    if (run)  st <= RUN;
            RUN:     if (!run) st <= HALT;
            HALT:    if (run)  st <= RUN;
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl -- self-checking bench for fetch_ctrl.
//
// A queue-based reference model tracks the FSM state, the PC, the buffered
// {pc, instr} entries and the fetch counter. After every clock edge all DUT
// outputs are compared against the model; directed scenarios also compare
// against hand-derived constants. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [31:0] mem_addr;
   logic [31:0] mem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [1:0]  state;
   logic [31:0] fetch_count;

   logic [31:0] mem [256];

   int checks   = 0;
   int failures = 0;

   // reference model state (state encoding: 0 idle, 1 running, 2 halted)
   entry_t      q [$];
   logic [31:0] m_pc;
   logic [31:0] m_fc;
   int          m_state;

   always #5 clk = ~clk;

   assign mem_instr = mem[mem_addr[9:2]];

   fetch_ctrl #(
      .RESET_PC (RESET_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .run            (run),
      .mem_addr       (mem_addr),
      .mem_instr      (mem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .state          (state),
      .fetch_count    (fetch_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance the model across one rising edge using the current inputs.
   task automatic model_edge();
      bit do_pop;
      bit do_push;
      if (rst) begin
         q.delete();
         m_pc    = RESET_PC;
         m_fc    = 32'h0;
         m_state = 0;
      end else if (redirect_valid) begin
         q.delete();
         m_pc = {redirect_pc[31:2], 2'b00};
      end else begin
         do_pop  = (q.size() > 0) && out_ready;
         do_push = (m_state == 1) && run && ((q.size() < DEPTH) || do_pop);
         if (do_pop)
            void'(q.pop_front());
         if (do_push) begin
            q.push_back('{pc: m_pc, instr: mem[m_pc[9:2]]});
            m_pc = m_pc + 32'd4;
            if (m_fc != 32'hFFFF_FFFF)
               m_fc = m_fc + 32'd1;
         end
         if (m_state == 0 && run)
            m_state = 1;
         else if (m_state == 1 && !run)
            m_state = 2;
         else if (m_state == 2 && run)
            m_state = 1;
      end
   endtask

   task automatic compare_all();
      check("out_valid",   32'(out_valid), (q.size() > 0) ? 32'd1 : 32'd0);
      check("out_pc",      out_pc,         (q.size() > 0) ? q[0].pc    : 32'h0);
      check("out_instr",   out_instr,      (q.size() > 0) ? q[0].instr : 32'h0);
      check("mem_addr",    mem_addr,       m_pc);
      check("state",       32'(state),     32'(m_state));
      check("fetch_count", fetch_count,    m_fc);
   endtask

   // One clock: drive inputs, let the edge happen, update model, compare at
   // the following falling edge.
   task automatic tick(input logic r, input logic rn, input logic rdy,
                       input logic rv, input logic [31:0] rp);
      rst            = r;
      run            = rn;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rp;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic do_reset();
      tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'h0;
      m_pc = 32'h0; m_fc = 32'h0; m_state = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h0030_8113;
      mem[2] = 32'h0021_01B3;

      // ---- streaming ----
      do_reset();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_instr", out_instr, 32'h0);
      check("rst_pc",    out_pc,    32'h0);
      check("rst_addr",  mem_addr,  RESET_PC);
      check("rst_state", 32'(state), 32'd0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_c1_valid", 32'(out_valid), 32'd0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_c2_pc",    out_pc,    32'h0);
      check("stream_c2_instr", out_instr, 32'h0050_0093);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_c3_pc",    out_pc,    32'h4);
      check("stream_c3_instr", out_instr, 32'h0030_8113);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_c4_pc",    out_pc,    32'h8);
      check("stream_c4_instr", out_instr, 32'h0021_01B3);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("stream_c5_pc",    out_pc,    32'hC);

      // ---- backpressure ----
      do_reset();
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("bp_addr",  mem_addr,  32'(4 * DEPTH));
      check("bp_pc",    out_pc,    32'h0);
      check("bp_instr", out_instr, 32'h0050_0093);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("bp_rel1_pc", out_pc, 32'h4);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("bp_rel2_pc", out_pc, 32'h8);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);

      // ---- redirect while full ----
      do_reset();
      for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_000B);
      check("redir_valid", 32'(out_valid), 32'd0);
      check("redir_addr",  mem_addr, 32'h8);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("redir_pc",    out_pc,    32'h8);
      check("redir_instr", out_instr, 32'h0021_01B3);

      // ---- halt and resume ----
      do_reset();
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("halt_state", 32'(state), 32'd2);
      check("halt_fc",    fetch_count, 32'd3);
      check("halt_drain", 32'(out_valid), 32'd0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check("halt_fc_frozen", fetch_count, 32'd3);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      check("resume_pc", out_pc, 32'hC);

      // ---- PC wrap, then reset with a full buffer ----
      do_reset();
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
      check("wrap_addr_pre", mem_addr, 32'hFFFF_FFFC);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap_addr_post", mem_addr, 32'h0);
      tick(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      check("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
      tick(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_addr",  mem_addr, RESET_PC);
      check("mid_rst_fc",    fetch_count, 32'h0);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         tick(($urandom % 64) == 0,
              ($urandom % 8) != 0,
              ($urandom % 3) != 0,
              ($urandom % 16) == 0,
              $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
